// File: rtl/hex_display_scanner_if.sv
// Bus between the display-value producer and the hex display scanner.
// The producer loads values; the scanner drives the decoder/anode outputs.
interface hex_display_scanner_if;
   logic [31:0] value_in;
   logic [7:0]  digit_en_in;
   logic        load;
   logic        load_done;
   logic [3:0]  nibble_out;
   logic [7:0]  an_out;
   logic        blank_out;

   modport master (
      output value_in, digit_en_in, load,
      input  load_done, nibble_out, an_out, blank_out
   );

   modport slave (
      input  value_in, digit_en_in, load,
      output load_done, nibble_out, an_out, blank_out
   );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller for an 8-digit common-anode hex display,
// with dead time between digits, leading-zero blanking and tear-free loads.
module hex_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 16,
   parameter int LZ_SUPPRESS = 1
) (
   input logic                  clk,
   input logic                  rst,
   hex_display_scanner_if.slave bus
);

   localparam int CNT_MAX0 = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
   localparam int CNT_W    = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

   typedef enum logic {
      ST_DEAD = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             boundary;

   logic [31:0] disp, disp_nxt, pend;
   logic [7:0]  en, en_nxt, pend_en;
   logic        pend_valid;

   // Digit 0 is never zero-suppressed; others hide when they and all digits above are zero.
   function automatic logic digit_visible(input logic [31:0] v, input logic [7:0] e,
                                          input logic [2:0] i);
      logic lz_hidden;
      lz_hidden = (LZ_SUPPRESS != 0) && (i != 3'd0) && ((v >> {i, 2'b00}) == 32'd0);
      return e[i] && !lz_hidden;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_DEAD;
         idx   <= 3'd7;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + CNT_W'(1);
      case (state)
         ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
               cnt_nxt = '0;
               if (DEAD_CYCLES == 0) begin
                  idx_nxt = idx + 3'd1;
               end else begin
                  state_nxt = ST_DEAD;
               end
            end
         end
         default: begin
            if ((DEAD_CYCLES == 0) || (cnt == DEAD_LAST)) begin
               cnt_nxt   = '0;
               idx_nxt   = idx + 3'd1;
               state_nxt = ST_SHOW;
            end
         end
      endcase
      boundary = (idx == 3'd7) && (idx_nxt == 3'd0);
   end

   // A load on the boundary edge itself bypasses the pending register.
   always_comb begin
      disp_nxt = disp;
      en_nxt   = en;
      if (boundary) begin
         if (bus.load) begin
            disp_nxt = bus.value_in;
            en_nxt   = bus.digit_en_in;
         end else if (pend_valid) begin
            disp_nxt = pend;
            en_nxt   = pend_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp          <= '0;
         en            <= '0;
         pend          <= '0;
         pend_en       <= '0;
         pend_valid    <= 1'b0;
         bus.load_done <= 1'b0;
         bus.an_out    <= 8'hFF;
         bus.nibble_out <= 4'h0;
         bus.blank_out <= 1'b1;
      end else begin
         disp          <= disp_nxt;
         en            <= en_nxt;
         bus.load_done <= boundary && (bus.load || pend_valid);
         if (boundary) begin
            pend_valid <= 1'b0;
         end else if (bus.load) begin
            pend       <= bus.value_in;
            pend_en    <= bus.digit_en_in;
            pend_valid <= 1'b1;
         end
         // Outputs take the value of the slot being entered on this edge.
         if (state_nxt == ST_SHOW) begin
            bus.nibble_out <= disp_nxt[{idx_nxt, 2'b00} +: 4];
            if (digit_visible(disp_nxt, en_nxt, idx_nxt)) begin
               bus.an_out    <= ~(8'b1 << idx_nxt);
               bus.blank_out <= 1'b0;
            end else begin
               bus.an_out    <= 8'hFF;
               bus.blank_out <= 1'b1;
            end
         end else begin
            bus.nibble_out <= 4'h0;
            bus.an_out     <= 8'hFF;
            bus.blank_out  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (REFRESH_DIV=4, DEAD_CYCLES=2);
// a second instance with leading-zero suppression off shares the stimulus.
module tb_hex_display_scanner;
   localparam int RDIV  = 4;
   localparam int DEAD  = 2;
   localparam int SLOT  = RDIV + DEAD;
   localparam int FRAME = 8 * SLOT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   hex_display_scanner_if bus_lz ();
   hex_display_scanner_if bus_nlz ();

   hex_display_scanner #(.REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD), .LZ_SUPPRESS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_lz)
   );

   hex_display_scanner #(.REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD), .LZ_SUPPRESS(0)) dut_nlz (
      .clk (clk),
      .rst (rst),
      .bus (bus_nlz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [31:0] v, input logic [7:0] e);
      bus_lz.load         = ld;
      bus_lz.value_in     = v;
      bus_lz.digit_en_in  = e;
      bus_nlz.load        = ld;
      bus_nlz.value_in    = v;
      bus_nlz.digit_en_in = e;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " an"},     {24'h0, bus_lz.an_out},     32'hFF);
      check({tag, " nib"},    {28'h0, bus_lz.nibble_out}, 32'h0);
      check({tag, " blank"},  {31'h0, bus_lz.blank_out},  32'h1);
      check({tag, " done"},   {31'h0, bus_lz.load_done},  32'h0);
      check({tag, " an2"},    {24'h0, bus_nlz.an_out},    32'hFF);
   endtask

   // Entered just after a frame-boundary edge; walks one frame and ends just after the next one.
   // ld*_t: frame cycle whose closing edge captures the load (-1 = none); stop_t aborts early.
   task automatic check_frame(input int fr, input logic exp_done, input logic [31:0] val,
                              input logic [7:0] vis, input logic [7:0] vis_nlz,
                              input int ld0_t, input logic [31:0] ld0_v, input logic [7:0] ld0_e,
                              input int ld1_t, input logic [31:0] ld1_v, input logic [7:0] ld1_e,
                              input int stop_t);
      for (int t = 0; t < FRAME; t++) begin
         int         k;
         int         c;
         logic [7:0] an_e;
         logic [7:0] an_e2;
         logic [3:0] nib_e;
         string      tg;
         if (t == stop_t) return;
         k  = t / SLOT;
         c  = t % SLOT;
         tg = $sformatf("f%0d s%0d c%0d", fr, k, c);
         nib_e = val[4*k +: 4];
         an_e  = (c < RDIV && vis[k])     ? ~(8'b1 << k) : 8'hFF;
         an_e2 = (c < RDIV && vis_nlz[k]) ? ~(8'b1 << k) : 8'hFF;
         check({tg, " an"},    {24'h0, bus_lz.an_out},    {24'h0, an_e});
         check({tg, " an2"},   {24'h0, bus_nlz.an_out},   {24'h0, an_e2});
         check({tg, " blank"}, {31'h0, bus_lz.blank_out}, {31'h0, (an_e == 8'hFF)});
         check({tg, " done"},  {31'h0, bus_lz.load_done}, {31'h0, (t == 0) ? exp_done : 1'b0});
         check({tg, " done2"}, {31'h0, bus_nlz.load_done}, {31'h0, (t == 0) ? exp_done : 1'b0});
         if (c < RDIV) begin
            check({tg, " nib"},  {28'h0, bus_lz.nibble_out},  {28'h0, nib_e});
            check({tg, " nib2"}, {28'h0, bus_nlz.nibble_out}, {28'h0, nib_e});
         end
         if (t == ld0_t)      drive(1'b1, ld0_v, ld0_e);
         else if (t == ld1_t) drive(1'b1, ld1_v, ld1_e);
         else                 drive(1'b0, 32'h0, 8'h00);
         tick();
      end
   endtask

   initial begin
      drive(1'b0, 32'h0, 8'h00);
      rst = 1'b1;
      tick();
      tick();
      check_idle("rst");
      rst = 1'b0;
      tick();
      check_idle("dead0");
      tick();
      // Frame 1: idle display, load arrives mid-frame and must not show yet.
      check_frame(1, 1'b0, 32'h0, 8'h00, 8'h00, 10, 32'h89ABCDEF, 8'hFF, -1, 32'h0, 8'h00, -1);
      check_frame(2, 1'b1, 32'h89ABCDEF, 8'hFF, 8'hFF, 20, 32'h00000050, 8'hFF, -1, 32'h0, 8'h00, -1);
      check_frame(3, 1'b1, 32'h00000050, 8'h03, 8'hFF, 5, 32'h00000000, 8'hFF, -1, 32'h0, 8'h00, -1);
      check_frame(4, 1'b1, 32'h00000000, 8'h01, 8'hFF, 7, 32'h11111111, 8'hA5, -1, 32'h0, 8'h00, -1);
      // Frame 5: two loads; only the second survives, one load_done follows.
      check_frame(5, 1'b1, 32'h11111111, 8'hA5, 8'hA5, 3, 32'h12345678, 8'hFF, 30, 32'h9ABCDEF0, 8'hFF, -1);
      // Frame 6: load on the closing boundary edge itself.
      check_frame(6, 1'b1, 32'h9ABCDEF0, 8'hFF, 8'hFF, FRAME - 1, 32'hAAAA5555, 8'hFF, -1, 32'h0, 8'h00, -1);
      // Frame 7: pending load, then reset in the middle of digit 3's SHOW slot.
      check_frame(7, 1'b1, 32'hAAAA5555, 8'hFF, 8'hFF, 5, 32'h0000FFFF, 8'hFF, -1, 32'h0, 8'h00, 3 * SLOT + 1);
      drive(1'b0, 32'h0, 8'h00);
      rst = 1'b1;
      tick();
      check_idle("rst2");
      rst = 1'b0;
      tick();
      check_idle("dead2");
      tick();
      check_frame(8, 1'b0, 32'h0, 8'h00, 8'h00, -1, 32'h0, 8'h00, -1, 32'h0, 8'h00, -1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode hex display.
- Holds a 32-bit display value and steps through digits 0..7 at a fixed rate.
- Outputs the current digit's nibble to the hex-to-7-segment decoder, plus the active-low anode select and a blanking flag.
- Inserts a dead time between digits against ghosting, suppresses leading zeros, and applies new values only at frame boundaries (tear-free).

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is lit (SHOW slot length), >=1.
- DEAD_CYCLES, 16: clock cycles with all anodes off between digits (DEAD slot), >=0; 0 removes DEAD.
- LZ_SUPPRESS, 1: 1 = blank leading zero digits; 0 = show all enabled digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- value_in  input  32  new display value; digit i = value_in[4i+3:4i]; digit 0 is rightmost.
- digit_en_in  input  8  per-digit enable, captured with value_in.
- load  input  1  one-cycle strobe: capture value_in/digit_en_in.
- load_done  output  1  one-cycle pulse when a captured load becomes the displayed value.
- nibble_out  output  4  nibble of the digit in the current SHOW slot, to the decoder input.
- an_out  output  8  anode select, active-low, at most one bit low.
- blank_out  output  1  1 = downstream must drive all segments off.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs registered.
- Reset:
  - an_out=8'hFF, nibble_out=0, blank_out=1, load_done=0.
  - Display register and pending register = 0; digit_en registers = 8'h00; pend_valid=0.
  - State = DEAD, idx=7, cnt=0.
- rst mid-operation aborts the slot immediately and clears any pending load (no load_done).
- FSM states:
  - SHOW: lasts REFRESH_DIV cycles. cnt counts 0..REFRESH_DIV-1. At cnt=REFRESH_DIV-1: go to DEAD with cnt=0, or, if DEAD_CYCLES=0, go straight to SHOW of the next index.
  - DEAD: lasts DEAD_CYCLES cycles. an_out=FF, blank_out=1. On its last cycle: idx <= (idx+1) mod 8, cnt=0, state=SHOW.
- Frame boundary: the edge where idx wraps 7->0. The first boundary comes DEAD_CYCLES cycles after reset release (immediately if DEAD_CYCLES=0).
- Digit visibility in SHOW slot idx. The digit is visible iff both hold:
  - digit_en[idx]=1, and
  - NOT (LZ_SUPPRESS=1 AND idx!=0 AND nibbles idx..7 of the display register are all 0).
  - Digit 0 is never zero-suppressed.
- Output timing: outputs take their slot value on the same edge the state enters the slot.
  - Visible: an_out=~(1<<idx), nibble_out=nibble[idx], blank_out=0.
  - Not visible: an_out=FF, blank_out=1, nibble_out=nibble[idx].
  - Slot time is always consumed, so the refresh period is constant: 8*(REFRESH_DIV+DEAD_CYCLES) cycles.
- Load handshake:
  - load=1 copies value_in/digit_en_in into the pending register and sets pend_valid.
  - A second load before the boundary overwrites pending; only one load_done follows.
  - At a frame boundary with pend_valid=1: display <= pending, pend_valid <= 0, load_done=1 for exactly that cycle. Digit 0 of the new frame already uses the new value.
  - load on the boundary edge itself: value_in bypasses pending and is committed directly on that edge; load_done pulses on that edge.
- Counter width: clog2(max(REFRESH_DIV, DEAD_CYCLES,2)). No overflow; cnt is compared for equality only.

Test Plan (REFRESH_DIV=4, DEAD_CYCLES=2, LZ_SUPPRESS=1 unless stated):
- Reset then idle -> outputs match reset values during DEAD. First boundary after 2 cycles. an_out=FF throughout (digit_en=0). Frame period = 48 cycles.
- load with value_in=32'h89ABCDEF, digit_en_in=FF -> load_done pulses at the next boundary. Digits 0..7 show nibbles F,E,D,C,B,A,9,8 with an_out FE,FD,FB,F7,EF,DF,BF,7F, each lit 4 cycles and separated by 2 FF cycles.
- load 32'h00000050, en=FF -> digits 0,1 lit (nibbles 0,5); digits 2..7 blank_out=1, an_out=FF. Same value with LZ_SUPPRESS=0 -> all 8 lit. Value 0 -> only digit 0 lit, showing 0.
- load 32'h11111111, en=8'hA5 -> only digits 0,2,5,7 drive anodes; frame timing unchanged.
- Two loads mid-frame (12345678, then 9ABCDEF0) -> exactly one load_done at the boundary; 9ABCDEF0 is displayed; no mid-frame change. A load on the boundary edge -> committed and load_done on that same edge.
- rst asserted during a SHOW slot of digit 3 with a load pending -> next edge gives reset outputs; after release, no load_done and the display is 0.
